// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier final stage
// Contents: rounding-mode and pipeline-state enums, the packed result record,
// and constructors for the fixed special results (qNaN, infinity, max finite).
package mul_pkg;

  localparam int FP_EXPO_W = 8;
  localparam int FP_MANT_W = 23;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rnd_mode_e;

  // Number of results currently held by the output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXPO_W-1:0] expo;
    logic [FP_MANT_W-1:0] mant;
    logic                 nv;
    logic                 of;
    logic                 uf;
    logic                 nx;
  } fp_res_t;

  function automatic fp_res_t fp_qnan();
    fp_res_t r;
    r      = '0;
    r.expo = '1;
    r.mant = {1'b1, {(FP_MANT_W-1){1'b0}}};
    return r;
  endfunction

  function automatic fp_res_t fp_inf(input logic s);
    fp_res_t r;
    r      = '0;
    r.sign = s;
    r.expo = '1;
    return r;
  endfunction

  function automatic fp_res_t fp_max_finite(input logic s);
    fp_res_t r;
    r      = '0;
    r.sign = s;
    r.expo = {{(FP_EXPO_W-1){1'b1}}, 1'b0};
    r.mant = '1;
    return r;
  endfunction

endpackage

// File: rtl/mul3_round.sv
// rtl/mul3_round.sv - combinational normalise, round, overflow and special override
// Ports:
//   sign_1, expo_1, mant_1   product sign, signed biased exponent, raw product
//   r_shift, l_shift         subnormal-result right shift / operand-normalise left shift
//   rnd_in                   rounding mode (rnd_mode_e encoding)
//   r_nan_in, inf_nan_in,
//   r_0nan_in, status_nv_in  special-case flags from stage 2
//   res                      finished result with status flags
module mul3_round
  import mul_pkg::*;
#(
  parameter  int EXPO_W = FP_EXPO_W,
  parameter  int MANT_W = FP_MANT_W,
  localparam int ZERO_D = $clog2(MANT_W + 1)
) (
  input  logic                  sign_1,
  input  logic [EXPO_W+1:0]     expo_1,
  input  logic [2*MANT_W+1:0]   mant_1,
  input  logic [ZERO_D:0]       r_shift,
  input  logic [ZERO_D:0]       l_shift,
  input  logic [1:0]            rnd_in,
  input  logic                  r_nan_in,
  input  logic                  inf_nan_in,
  input  logic                  r_0nan_in,
  input  logic                  status_nv_in,
  output fp_res_t               res
);

  localparam int PW = 2*MANT_W + 2;
  // One extra bit over expo_1 so +1 (normalise) and +1 (round carry) never wrap.
  localparam int EW = EXPO_W + 3;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((2**EXPO_W) - 1);

  logic [PW-1:0]          lost_mask;
  logic [PW-1:0]          shifted;
  logic                   sticky_shift;
  logic [PW-2:0]          m;          // normalised: bit PW-2 is the hidden bit
  logic signed [EW-1:0]   e;
  logic signed [EW-1:0]   e_rnd;
  logic [MANT_W-1:0]      frac;
  logic [MANT_W:0]        sum;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic                   carry;
  logic                   subn;
  logic                   nx;
  logic                   ovf;
  logic                   to_inf;

  always_comb begin
    lost_mask    = ~({PW{1'b1}} << r_shift);
    shifted      = '0;
    sticky_shift = 1'b0;
    if (r_shift != '0) begin
      shifted      = mant_1 >> r_shift;
      sticky_shift = |(mant_1 & lost_mask);
    end else begin
      shifted      = mant_1 << l_shift;
    end

    e = {expo_1[EXPO_W+1], expo_1};
    if (shifted[PW-1]) begin
      m      = shifted[PW-1:1];
      sticky = sticky_shift | shifted[0];
      e      = e + E_ONE;
    end else begin
      m      = shifted[PW-2:0];
      sticky = sticky_shift;
    end

    frac   = m[2*MANT_W-1:MANT_W];
    guard  = m[MANT_W-1];
    sticky = sticky | (|m[MANT_W-2:0]);
    nx     = guard | sticky;

    case (rnd_in)
      RNE:     inc = guard & (sticky | frac[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign_1 & nx;
      default: inc = ~sign_1 & nx;
    endcase

    sum   = {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    carry = sum[MANT_W];
    subn  = (r_shift != '0) | ~m[2*MANT_W];

    // A carry out of a subnormal fraction lands exactly on the smallest normal.
    if (subn) e_rnd = carry ? E_ONE : '0;
    else      e_rnd = carry ? (e + E_ONE) : e;

    ovf    = ~subn & (e_rnd >= E_MAX);
    to_inf = (rnd_in == RNE) | ((rnd_in == RUP) & ~sign_1) | ((rnd_in == RDN) & sign_1);

    res      = '0;
    res.sign = sign_1;
    if (r_nan_in) begin
      res = fp_qnan();
    end else if (inf_nan_in) begin
      res = fp_inf(sign_1);
    end else if (r_0nan_in) begin
      res.sign = sign_1;
    end else if (ovf) begin
      res    = to_inf ? fp_inf(sign_1) : fp_max_finite(sign_1);
      res.of = 1'b1;
      res.nx = 1'b1;
    end else begin
      res.expo = e_rnd[EXPO_W-1:0];
      res.mant = sum[MANT_W-1:0];
      res.uf   = nx & subn;
      res.nx   = nx;
    end
    res.nv = status_nv_in;
  end

endmodule

// File: rtl/mul_pipe3.sv
// rtl/mul_pipe3.sv - multiplier final stage with valid/ready and two-entry skid
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      stage-2 handshake (in_ready is a flop)
//   sign_1 .. status_nv_in   stage-2 payload, see mul3_round
//   out_valid / out_ready    consumer handshake
//   r_sign, r_expo, r_mant   result fields, held stable while stalled
//   status_nv/of/uf/nx       invalid, overflow, underflow, inexact
module mul_pipe3
  import mul_pkg::*;
#(
  parameter  int SIGN_W = 1,
  parameter  int EXPO_W = FP_EXPO_W,
  parameter  int MANT_W = FP_MANT_W,
  localparam int ZERO_D = $clog2(MANT_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIGN_W-1:0]     sign_1,
  input  logic [EXPO_W+1:0]     expo_1,
  input  logic [2*MANT_W+1:0]   mant_1,
  input  logic [ZERO_D:0]       r_shift,
  input  logic [ZERO_D:0]       l_shift,
  input  logic [1:0]            rnd_in,
  input  logic                  r_nan_in,
  input  logic                  inf_nan_in,
  input  logic                  r_0nan_in,
  input  logic                  status_nv_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIGN_W-1:0]     r_sign,
  output logic [EXPO_W-1:0]     r_expo,
  output logic [MANT_W-1:0]     r_mant,
  output logic                  status_nv,
  output logic                  status_of,
  output logic                  status_uf,
  output logic                  status_nx
);

  pipe_state_e state_q, state_d;
  fp_res_t     res, out_q, skid_q;
  logic        accept, drain;
  logic        load_out, load_skid, skid_to_out;

  mul3_round #(
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_round (
    .sign_1       (sign_1),
    .expo_1       (expo_1),
    .mant_1       (mant_1),
    .r_shift      (r_shift),
    .l_shift      (l_shift),
    .rnd_in       (rnd_in),
    .r_nan_in     (r_nan_in),
    .inf_nan_in   (inf_nan_in),
    .r_0nan_in    (r_0nan_in),
    .status_nv_in (status_nv_in),
    .res          (res)
  );

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: if (drain) begin
        state_d     = ONE;
        skid_to_out = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
      if (load_out)         out_q <= res;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= res;
    end
  end

  assign r_sign    = out_q.sign;
  assign r_expo    = out_q.expo;
  assign r_mant    = out_q.mant;
  assign status_nv = out_q.nv;
  assign status_of = out_q.of;
  assign status_uf = out_q.uf;
  assign status_nx = out_q.nx;

endmodule

// File: tb/tb_mul_pipe3.sv
// tb/tb_mul_pipe3.sv - self-checking bench for mul_pipe3 (FP32 configuration)
module tb_mul_pipe3;

  typedef struct packed {
    logic        s;
    logic [9:0]  ex;
    logic [47:0] mt;
    logic [5:0]  rs;
    logic [5:0]  ls;
    logic [1:0]  rnd;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        nv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  vec_t        cur = '0;
  logic        in_ready, out_valid;
  logic        r_sign;
  logic [7:0]  r_expo;
  logic [22:0] r_mant;
  logic        status_nv, status_of, status_uf, status_nx;

  int n_cmp = 0;
  int n_bad = 0;
  int n_drained = 0;

  always #5 clk = ~clk;

  mul_pipe3 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_1       (cur.s),
    .expo_1       (cur.ex),
    .mant_1       (cur.mt),
    .r_shift      (cur.rs),
    .l_shift      (cur.ls),
    .rnd_in       (cur.rnd),
    .r_nan_in     (cur.nan),
    .inf_nan_in   (cur.inf),
    .r_0nan_in    (cur.zero),
    .status_nv_in (cur.nv),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .r_sign       (r_sign),
    .r_expo       (r_expo),
    .r_mant       (r_mant),
    .status_nv    (status_nv),
    .status_of    (status_of),
    .status_uf    (status_uf),
    .status_nx    (status_nx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [9:0] ex, input logic [47:0] mt,
                              input logic [5:0] rs, input logic [5:0] ls,
                              input logic [1:0] rnd, input logic [3:0] sp);
    vec_t v;
    v.s = s; v.ex = ex; v.mt = mt; v.rs = rs; v.ls = ls; v.rnd = rnd;
    {v.nan, v.inf, v.zero, v.nv} = sp;
    return v;
  endfunction

  // Exact-value model: keep 64 extra fraction bits so no shift loses anything,
  // then round by comparing the discarded remainder against one half ulp.
  // Returns {nv, of, uf, nx, sign, expo[7:0], mant[22:0]}.
  function automatic logic [35:0] model(input vec_t v);
    logic [127:0] x, q, rem, half;
    logic [23:0]  frac2;
    logic [31:0]  word;
    logic         nx, inc, subn, carry, of, uf, to_inf;
    int           k, e, ex;
    x = 128'(v.mt) << 64;
    if (v.rs != 0) x = x >> v.rs;
    else           x = x << v.ls;
    e = int'($signed(v.ex));
    k = 87;
    if (x[111]) begin
      k = 88;
      e = e + 1;
    end
    q    = x >> k;
    rem  = x - (q << k);
    half = 128'd1 << (k - 1);
    nx   = (rem != 0);
    case (v.rnd)
      2'b00:   inc = (rem > half) || ((rem == half) && q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = v.s & nx;
      default: inc = ~v.s & nx;
    endcase
    subn  = (v.rs != 0) || !q[23];
    frac2 = {1'b0, q[22:0]} + {23'd0, inc};
    carry = frac2[23];
    ex    = subn ? int'(carry) : e + int'(carry);
    uf    = nx & subn;
    of    = !subn && (ex >= 255);
    if (of) begin
      nx     = 1'b1;
      to_inf = (v.rnd == 2'b00) || (v.rnd == 2'b11 && !v.s) || (v.rnd == 2'b10 && v.s);
      word   = to_inf ? {v.s, 8'hFF, 23'h0} : {v.s, 8'hFE, 23'h7FFFFF};
    end else begin
      word = {v.s, ex[7:0], frac2[22:0]};
    end
    if (v.nan)  return {v.nv, 3'b000, 32'h7FC00000};
    if (v.inf)  return {v.nv, 3'b000, v.s, 8'hFF, 23'h0};
    if (v.zero) return {v.nv, 3'b000, v.s, 31'h0};
    return {v.nv, of, uf, nx, word};
  endfunction

  // Scoreboard: queue holds the results the stage should currently be holding.
  logic [35:0] sb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid && sb.size() != 0)
        check("stream", 64'({status_nv, status_of, status_uf, status_nx, r_sign, r_expo, r_mant}),
              64'(sb[0]));
      if (out_valid && out_ready && sb.size() != 0) begin
        void'(sb.pop_front());
        n_drained++;
      end
      if (in_valid && in_ready) sb.push_back(model(cur));
    end
  end

  task automatic run_vec(input string name, input vec_t v, input logic [31:0] exp_w,
                         input logic [3:0] exp_f);
    check({name, " model"}, 64'(model(v)), 64'({exp_f, exp_w}));
    out_ready = 1'b1;
    cur       = v;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " valid"}, 64'(out_valid), 64'd1);
    check(name, 64'({status_nv, status_of, status_uf, status_nx, r_sign, r_expo, r_mant}),
          64'({exp_f, exp_w}));
  endtask

  vec_t va, vb, vc;
  int   d0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset data", 64'({status_nv, status_of, status_uf, status_nx, r_sign, r_expo, r_mant}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    va = mk(0, 10'd127, 48'h900000000000, 0, 0, 2'b00, 4'b0000);
    vb = mk(0, 10'd127, 48'h400000C00000, 0, 0, 2'b00, 4'b0000);
    vc = mk(0, 10'd10,  48'h000000800000, 0, 23, 2'b00, 4'b0000);

    run_vec("1.5x1.5",      va, 32'h40100000, 4'b0000);
    run_vec("rne tie even", mk(0, 10'd127, 48'h400000400000, 0, 0, 2'b00, 4'b0000), 32'h3F800000, 4'b0001);
    run_vec("rne tie odd",  vb, 32'h3F800002, 4'b0001);
    run_vec("lshift",       vc, 32'h05000000, 4'b0000);
    run_vec("rup pos",      mk(0, 10'd127, 48'h400000000001, 0, 0, 2'b11, 4'b0000), 32'h3F800001, 4'b0001);
    run_vec("rdn neg",      mk(1, 10'd127, 48'h400000000001, 0, 0, 2'b10, 4'b0000), 32'hBF800001, 4'b0001);
    run_vec("rtz neg",      mk(1, 10'd127, 48'h400000000001, 0, 0, 2'b01, 4'b0000), 32'hBF800000, 4'b0001);
    run_vec("carry norm",   mk(0, 10'd127, 48'h7FFFFFFFFFFF, 0, 0, 2'b00, 4'b0000), 32'h40000000, 4'b0001);
    run_vec("ovf rtz",      mk(0, 10'd300, 48'h400000000000, 0, 0, 2'b01, 4'b0000), 32'h7F7FFFFF, 4'b0101);
    run_vec("ovf rne",      mk(0, 10'd300, 48'h400000000000, 0, 0, 2'b00, 4'b0000), 32'h7F800000, 4'b0101);
    run_vec("ovf rdn pos",  mk(0, 10'd300, 48'h400000000000, 0, 0, 2'b10, 4'b0000), 32'h7F7FFFFF, 4'b0101);
    run_vec("ovf rdn neg",  mk(1, 10'd300, 48'h400000000000, 0, 0, 2'b10, 4'b0000), 32'hFF800000, 4'b0101);
    run_vec("ovf rup neg",  mk(1, 10'd300, 48'h400000000000, 0, 0, 2'b11, 4'b0000), 32'hFF7FFFFF, 4'b0101);
    run_vec("max exact",    mk(0, 10'd254, 48'h400000000000, 0, 0, 2'b00, 4'b0000), 32'h7F000000, 4'b0000);
    run_vec("ovf by carry", mk(0, 10'd254, 48'h7FFFFFFFFFFF, 0, 0, 2'b00, 4'b0000), 32'h7F800000, 4'b0101);
    run_vec("subnormal",    mk(0, 10'd0,   48'h400000000007, 3, 0, 2'b00, 4'b0000), 32'h00100000, 4'b0011);
    run_vec("sub to norm",  mk(0, 10'd0,   48'h7FFFFFFFFFFF, 1, 0, 2'b00, 4'b0000), 32'h00800000, 4'b0011);
    run_vec("nan prio",     mk(1, 10'd300, 48'h900000000000, 0, 0, 2'b00, 4'b1101), 32'h7FC00000, 4'b1000);
    run_vec("inf neg",      mk(1, 10'd127, 48'h900000000000, 0, 0, 2'b00, 4'b0100), 32'hFF800000, 4'b0000);
    run_vec("zero neg",     mk(1, 10'd300, 48'h400000000001, 0, 0, 2'b00, 4'b0010), 32'h80000000, 4'b0000);
    run_vec("nv pass",      mk(0, 10'd127, 48'h900000000000, 0, 0, 2'b00, 4'b0001), 32'h40100000, 4'b1000);

    // Drain the last result, then stall with three offered inputs.
    out_ready = 1'b1;
    @(posedge clk); #1;
    d0 = n_drained;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = va;
    @(posedge clk); #1;
    cur = vb;
    @(posedge clk); #1;
    cur = vc;
    @(posedge clk); #1;
    check("stall in_ready", 64'(in_ready), 64'd0);
    check("stall out_valid", 64'(out_valid), 64'd1);
    check("stall head", 64'({r_sign, r_expo, r_mant}), 64'h40100000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release second", 64'({r_sign, r_expo, r_mant}), 64'h3F800002);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release third", 64'({r_sign, r_expo, r_mant}), 64'h05000000);
    @(posedge clk); #1;
    check("drain count", 64'(n_drained - d0), 64'd3);
    check("drained empty", 64'(out_valid), 64'd0);

    // Fill both entries, then reset asynchronously mid-stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = va;
    @(posedge clk); #1;
    cur = vb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst data", 64'({status_nv, status_of, status_uf, status_nx, r_sign, r_expo, r_mant}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after reset", vc, 32'h05000000, 4'b0000);
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_pipe3.md
Name: mul_pipe3

Overview:
- Third (final) stage of the floating-point multiplier pipeline; consumes the raw product, exponent, shift amounts, rounding mode and special-case flags produced by stage 2.
- Performs normalisation shift, rounding, overflow/underflow handling and special-value override.
- Adds a valid/ready handshake with a two-entry skid buffer so the multiplier can be back-pressured by its consumer.
- Registered output; fixed one-cycle latency when unstalled.

Parameters:
SIGN_W, 1, sign width (fixed 1)
EXPO_W, 8, exponent field width
MANT_W, 23, stored mantissa width (no hidden bit)
ZERO_D, $clog2(MANT_W+1), localparam, shift-amount width minus one

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  stage-2 data valid
in_ready  out  1  stage 3 can accept
sign_1  in  1  product sign
expo_1  in  EXPO_W+2  biased product exponent, two's complement
mant_1  in  2*MANT_W+2  raw significand product; binary point between bits 2*MANT_W and 2*MANT_W-1
r_shift  in  ZERO_D+1  right shift for subnormal result
l_shift  in  ZERO_D+1  left shift for subnormal-operand normalisation
rnd_in  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
r_nan_in  in  1  result is NaN
inf_nan_in  in  1  result is infinity
r_0nan_in  in  1  result is zero
status_nv_in  in  1  invalid-operation flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
r_sign  out  1  result sign
r_expo  out  EXPO_W  result exponent
r_mant  out  MANT_W  result mantissa
status_nv/of/uf/nx  out  1 each  invalid, overflow, underflow, inexact

Behaviour:
- Reset (async, rst_n low): out_valid=0, in_ready=1, all data and status outputs 0, FSM state EMPTY. Reset mid-transfer discards held entries.
- FSM states and transitions (count of held results):
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without drain.
  - ONE -> EMPTY on drain without accept.
  - TWO -> ONE on drain.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- TWO: output register holds the oldest result and the skid register holds the next. On drain, skid moves to output in the same edge.
- ONE with simultaneous accept and drain: new result loads the output register; state stays ONE.
- Output data stays stable while out_valid=1 and out_ready=0.
- Datapath (combinational before capture):
  - m = r_shift!=0 ? mant_1 >> r_shift, with sticky = OR of shifted-out bits : mant_1 << l_shift.
  - If m[2*MANT_W+1]=1: shift right by 1 (folding the lost bit into sticky) and e = expo_1+1; otherwise e = expo_1.
  - Fraction = m[2*MANT_W-1:MANT_W]; guard = m[MANT_W-1]; sticky |= OR(m[MANT_W-2:0]).
  - Round increment:
    - RNE: guard & (sticky | lsb).
    - RTZ: 0.
    - RDN: sign & (guard | sticky).
    - RUP: ~sign & (guard | sticky).
  - Mantissa carry-out increments e and zeroes the fraction. A subnormal rounding up to 1.0 sets e=1.
  - r_shift!=0 or hidden bit 0 -> r_expo=0 (subnormal).
  - uf = nx & (r_expo==0 before rounding); nx = guard|sticky.
- Overflow when e >= 2^EXPO_W-1, signed compare: of=1, nx=1.
  - Result is infinity for RNE, for RUP with positive sign, and for RDN with negative sign.
  - Otherwise result is max finite: expo all-ones minus 1, mant all-ones.
- Special overrides, priority r_nan > inf_nan > r_0nan:
  - r_nan: canonical qNaN (sign 0, expo all-ones, mant MSB only).
  - inf_nan: signed infinity.
  - r_0nan: signed zero.
  - Overrides force of/uf/nx to 0. status_nv passes through.

Decomposition:
- Package mul_pkg:
  - rnd_mode_e enum (RNE/RTZ/RDN/RUP).
  - pipe_state_e enum (EMPTY/ONE/TWO).
  - fp_res_t packed struct (sign, expo, mant, nv, of, uf, nx).
  - Functions for qNaN/inf/max-finite constants.
- Sub-module mul3_round: purely combinational normalise/round/override producing fp_res_t.
- mul_pipe3 holds the FSM and the two fp_res_t registers.

Test Plan:
- FP32, 1.5×1.5: mant_1=0x900000000000, expo_1=127, shifts 0, RNE, out_ready=1 -> one cycle later r_sign/expo/mant = 0x40100000, no flags.
- RNE tie-to-even: mant_1 with fraction lsb=0, guard=1, sticky=0 -> no increment, nx=1. Same with lsb=1 -> increment.
- Overflow: expo_1=300, RTZ -> 0x7F7FFFFF with of=1, nx=1. Same with RNE -> 0x7F800000.
- Subnormal: r_shift=3 with bits shifted out -> r_expo=0, uf=1, nx=1.
- Special priority: r_nan_in=1 and inf_nan_in=1, status_nv_in=1 -> 0x7FC00000, nv=1, of=uf=nx=0.
- Back-pressure:
  - out_ready=0 for 3 cycles while in_valid=1 -> two results held, in_ready=0 after second accept.
  - Release out_ready -> results emerge in order with no loss or duplication.
  - Assert rst_n=0 mid-stall -> out_valid=0 immediately.
